// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control for a combinational instruction ROM.
// Sequences the PC from a start address, applies absolute or PC-relative branches
// through a writable jump-target table, stops on halt and counts retired instructions.
module fetch_unit #(
    parameter int PC_W  = 12,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic [IDX_W-1:0] BranchIdx,
    input  logic             BranchRel,
    input  logic             LutWe,
    input  logic [IDX_W-1:0] LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  InstAddress,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount
);

    localparam int LUT_N = 1 << IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [PC_W-1:0]  lut_entry;

    // Kept in flops rather than RAM: reset must clear every entry at once.
    logic [PC_W-1:0]  lut_q [LUT_N];

    // Read side sees the pre-edge contents, so a same-cycle write is not forwarded.
    assign lut_entry = lut_q[BranchIdx];

    // Retired-instruction counter sticks at its maximum instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Jump-target table: cleared by reset, otherwise one entry written per edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (LutWe) begin
            lut_q[LutAddr] <= LutData;
        end
    end

    // Next-state selection: halt beats branch beats sequential; stall freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (!Stall) begin
                    cnt_d = cnt_inc;
                    if (Halt) begin
                        state_d = S_DONE;
                    end else if (BranchEn) begin
                        // Relative entries are two's complement; the PC-width add wraps naturally.
                        pc_d = BranchRel ? (pc_q + lut_entry) : lut_entry;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                // IDLE and DONE both (re)start on Start; the unused encoding behaves like IDLE.
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State, PC and counter registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstCount   = cnt_q;
    assign Running     = (state_q == S_RUN);
    assign Done        = (state_q == S_DONE);

endmodule
